// File: rtl/fifo_defines_pkg.sv
// Shared defaults and pointer types for the generator sample FIFO.
// Error-flag ports are enabled in the top with `define GEN_FIFO_ERR_FLAGS_EN.
package fifo_defines_pkg;

    localparam int unsigned GEN_DATA_WIDTH = 16;
    localparam int unsigned GEN_FIFO_DEPTH = 8;
    localparam int unsigned GEN_PTR_BITS   = $clog2(GEN_FIFO_DEPTH);

    // One extra MSB over the address so full and empty are distinguishable.
    typedef logic [GEN_PTR_BITS:0] fifo_ptr_t;
    typedef logic [GEN_PTR_BITS:0] fifo_count_t;

endpackage

// File: rtl/gen_fifo_ram.sv
// Dual-port register file: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module gen_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_BITS-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_BITS-1:0]  i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-edge read of the slot being overwritten returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gen_sample_fifo.sv
// Sample buffer between the function generator and its consumer.
// Optional sticky overflow/underflow flags: `define GEN_FIFO_ERR_FLAGS_EN.
module gen_sample_fifo
    import fifo_defines_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GEN_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = GEN_FIFO_DEPTH,
    parameter int unsigned PTR_BITS   = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [PTR_BITS:0]     count_o
`ifdef GEN_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow_o,
    output logic                  underflow_o
`endif
);

    logic [PTR_BITS:0] r_wr_ptr;
    logic [PTR_BITS:0] r_rd_ptr;
    logic              r_valid;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]) &&
                     (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]);

    // Flush overrides both requests; a full FIFO still accepts a write
    // when the same edge frees a slot.
    assign w_rd_acc = rd_en_i & ~w_empty & ~clrh_i;
    assign w_wr_acc = wr_en_i & (~w_full | w_rd_acc) & ~clrh_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
        end else if (clrh_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + (PTR_BITS+1)'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + (PTR_BITS+1)'(1);
            end
            r_valid <= w_rd_acc;
        end
    end

    gen_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (PTR_BITS)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_acc),
        .i_wr_addr  (r_wr_ptr[PTR_BITS-1:0]),
        .i_wr_data  (data_i),
        .i_rd_en    (w_rd_acc),
        .i_rd_addr  (r_rd_ptr[PTR_BITS-1:0]),
        .o_rd_data  (data_o)
    );

    assign valid_o = r_valid;
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign count_o = r_wr_ptr - r_rd_ptr;

`ifdef GEN_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clrh_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en_i & w_full & ~w_rd_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en_i & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_gen_sample_fifo.sv
// Self-checking bench for gen_sample_fifo against a queue-based reference.
// Honours `define GEN_FIFO_ERR_FLAGS_EN for the sticky error flags.
module tb_gen_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clrh_i;
    logic          wr_en_i;
    logic [DW-1:0] data_i;
    logic          rd_en_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          full_o;
    logic          empty_o;
    logic [3:0]    count_o;
`ifdef GEN_FIFO_ERR_FLAGS_EN
    logic          overflow_o;
    logic          underflow_o;
`endif

    always #5 clk = ~clk;

    gen_sample_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clrh_i     (clrh_i),
        .wr_en_i    (wr_en_i),
        .data_i     (data_i),
        .rd_en_i    (rd_en_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o)
`ifdef GEN_FIFO_ERR_FLAGS_EN
        ,
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  32'(data_o),  32'(m_dout));
        chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        chk({tag, ".count"}, 32'(count_o), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(empty_o), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(full_o),  32'(m_q.size() == DEPTH));
`ifdef GEN_FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic clr, input string tag);
        bit full_b, empty_b, rd_acc, wr_acc;
        wr_en_i = wr;
        data_i  = d;
        rd_en_i = rd;
        clrh_i  = clr;
        @(posedge clk);
        full_b  = (m_q.size() == DEPTH);
        empty_b = (m_q.size() == 0);
        if (clr) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rd_acc = rd && !empty_b;
            wr_acc = wr && (!full_b || rd_acc);
            if (wr && full_b && !rd_acc) m_ovf = 1'b1;
            if (rd && empty_b)           m_unf = 1'b1;
            m_valid = rd_acc;
            if (rd_acc) m_dout = m_q.pop_front();
            if (wr_acc) m_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst     = 1'b1;
        clrh_i  = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        data_i  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");
        chk("reset.data_const", 32'(data_o), 32'h0000);
        step(1'b0, '0, 1'b0, 1'b0, "idle");

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "fill");
        chk("fill.full_const",  32'(full_o),  32'd1);
        chk("fill.count_const", 32'(count_o), 32'd8);
        step(1'b1, 16'h7FFF, 1'b0, 1'b0, "overflow");
        chk("overflow.count_const", 32'(count_o), 32'd8);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, "drain");
            chk("drain.data_const", 32'(data_o), 32'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0, "underflow");
        chk("underflow.data_const",  32'(data_o),  32'h0008);
        chk("underflow.valid_const", 32'(valid_o), 32'd0);

        for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0, "refill");
        step(1'b1, 16'h8000, 1'b1, 1'b0, "full_rw");
        chk("full_rw.count_const", 32'(count_o), 32'd8);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, "full_rw_drain");
        step(1'b0, '0, 1'b1, 1'b0, "full_rw_last");
        chk("full_rw.data_const", 32'(data_o), 32'h8000);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(16'hFFF0 + i), 1'b0, 1'b0, "pair_wr");
            step(1'b0, '0, 1'b1, 1'b0, "pair_rd");
            chk("pair.data_const", 32'(data_o), 32'(DW'(16'hFFF0 + i)));
        end
        step(1'b1, 16'h1234, 1'b1, 1'b0, "empty_rw");

        for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0A00 + i), 1'b0, 1'b0, "pre_flush");
        step(1'b1, 16'h5555, 1'b1, 1'b1, "flush");
        chk("flush.count_const", 32'(count_o), 32'd0);
        chk("flush.empty_const", 32'(empty_o), 32'd1);

        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0B00 + i), 1'b0, 1'b0, "pre_rst");
        step(1'b0, '0, 1'b1, 1'b0, "pre_rst_rd");
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;

        for (int n = 0; n < 400; n++) begin
            step(1'b1 & $urandom_range(0, 1), DW'($urandom), 1'b1 & $urandom_range(0, 1),
                 ($urandom_range(0, 31) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
